sram_burst_scan_subsystem: RTL
==============================

Name: sram_burst_scan_subsystem

Overview:
Parametrised successor to the single-beat SRAM test design. It pairs a scan-testable memory controller with an on-chip synchronous SRAM and adds two things the single-beat design lacks: programmable-length burst reads and writes, and out-of-range address detection. All controller flops sit on one mux-D scan chain; the SRAM array is not scanned.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data word width
DEPTH, 256, number of implemented words (must be <= 2**ADDR_W)
LEN_W, 4, burst length field width; a burst moves len_in+1 beats (max 16)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
scan_en  in  1  1 = all controller flops shift; functional update and SRAM writes are suppressed
scan_in  in  1  scan chain serial input
scan_out  out  1  scan chain serial output
start_op  in  1  operation request, sampled only in IDLE
op_type  in  2  00 single read, 01 single write, 10 burst read, 11 burst write
addr_in  in  ADDR_W  start address
len_in  in  LEN_W  beats minus 1; forced to 0 for single ops
data_in  in  DATA_W  write data; consumed on every cycle where wdata_ready=1
wdata_ready  out  1  high in WR; a write beat is taken in that cycle
data_out  out  DATA_W  registered read data; holds its value between reads
rdata_valid  out  1  data_out carries a new beat this cycle
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at the end of an operation
err  out  1  one-cycle pulse coincident with done on a rejected request

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0 and all controller registers 0. SRAM contents are not cleared.
- States: IDLE, RD, WR, DONE, ERR (3-bit encoding from package).
- IDLE -> capture:
  - Transition occurs when start_op=1 and scan_en=0.
  - Captured: op, cur_addr=addr_in, count = len_in (bursts) or 0 (single ops).
  - Range check is done in ADDR_W+1 bits: addr_in+count >= DEPTH -> ERR, with no memory access.
  - Otherwise go to RD or WR.
- WR:
  - wdata_ready=1; mem[cur_addr] <= data_in at the clock edge.
  - If count==0, go to DONE; else cur_addr++ and count--.
- RD:
  - The read address is presented each cycle; the SRAM has 1-cycle synchronous read.
  - data_out and rdata_valid are registered, so each beat appears the cycle after issue.
  - If count==0, go to DONE; else cur_addr++ and count--.
  - The last beat's rdata_valid=1 coincides with DONE.
- DONE: done=1, then IDLE. ERR: done=1 and err=1, then IDLE.
- Latency (start sampled at edge 0):
  - Single write: done in cycle 2.
  - Single read: data_out valid and done both in cycle 2.
  - Burst of N beats: done in cycle N+1.
  - Reads: beats valid in cycles 2..N+1, back-to-back.
- Ignored requests: start_op is ignored while busy=1 or scan_en=1.
- No wrap-around: any request that would cross DEPTH-1 is rejected via ERR.
- Scan:
  - scan_en=1 overrides state and all registers. Each flop takes its chain predecessor.
  - SRAM write enable is forced to 0.
  - Chain order from scan_in: state[0..2], op[0..1], cur_addr[0..ADDR_W-1], count[0..LEN_W-1], data_out[0..DATA_W-1], done, err, rdata_valid -> scan_out.
  - Chain length = 8+ADDR_W+LEN_W+DATA_W (28 at defaults).
  - After scan_en falls, the controller resumes from whatever state was shifted in. Illegal state codes go to IDLE.
- Reset mid-operation: the operation is aborted immediately and no done is issued. A partially written burst leaves earlier beats in memory.
- Simultaneous reset and scan_en: reset wins.

Decomposition:
- Package sram_ctrl_pkg holds:
  - op codes OP_RD, OP_WR, OP_BRD, OP_BWR;
  - state encoding ST_IDLE=0, ST_RD=1, ST_WR=2, ST_DONE=3, ST_ERR=4;
  - a helper function for chain length.
- Sub-module sram_array_p (params ADDR_W, DATA_W, DEPTH) holds the memory only:
  - synchronous write;
  - 1-cycle registered read;
  - no reset.
- The controller FSM and scan mux live in the top.

Test Plan:
- Single write then single read: write 0xA5 at addr 0x10, then read 0x10. Expect done in cycle 2 of each operation; read gives data_out=0xA5 with rdata_valid in cycle 2.
- Burst write then burst read: write len_in=3 from addr 0x20 with data 0x01..0x04, then read back. Expect 4 consecutive rdata_valid beats 0x01,0x02,0x03,0x04 and done on the last one.
- Range error: DEPTH=256, addr 0xFE, burst len_in=3. Expect err=done=1 in cycle 1; mem[0xFE], mem[0xFF] and mem[0x00] unchanged.
- Scan shift: with scan_en=1, shift 28 bits of pattern 0xA5C3F0F; the same bits appear on scan_out 28 cycles later. Also check that a concurrent start_op is ignored and no SRAM location changes.
- Reset mid-burst: assert rst low in the 2nd beat of an 8-beat write. Expect all outputs 0 immediately, no done, and beat 1 present in memory.
- Busy ignore: pulse start_op during a burst read. Expect exactly one done and no extra beats.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared op codes, state encoding and scan-chain sizing for the burst SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_BRD = 2'b10,
        OP_BWR = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // state(3) + op(2) + done/err/rdata_valid(3) plus the three data-path registers
    function automatic int unsigned chain_len(input int unsigned addr_w,
                                              input int unsigned len_w,
                                              input int unsigned data_w);
        return 8 + addr_w + len_w + data_w;
    endfunction

endpackage

// File: rtl/sram_array_p.sv
// Single-port-style SRAM array: synchronous write, one-cycle registered read, no reset.
module sram_array_p #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              rd_ok;

    // Only a partially populated address space needs a bounds guard.
    if (DEPTH == (2 ** ADDR_W)) begin : g_full
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_part
        assign wr_ok = (32'(wr_addr) < DEPTH);
        assign rd_ok = (32'(rd_addr) < DEPTH);
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_ok) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sram_burst_scan_subsystem.sv
// Burst read/write SRAM controller with range checking; every controller flop sits on one scan chain.
module sram_burst_scan_subsystem
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    input  logic              start_op,
    input  logic [1:0]        op_type,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              rdata_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CHAIN_L = chain_len(ADDR_W, LEN_W, DATA_W);

    // Field order from LSB upward is the scan order from scan_in.
    typedef struct packed {
        logic              rdata_valid;
        logic              err;
        logic              done;
        logic [DATA_W-1:0] data_out;
        logic [LEN_W-1:0]  count;
        logic [ADDR_W-1:0] cur_addr;
        op_t               op;
        state_t            state;
    } ctrl_t;

    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;
    logic [DATA_W-1:0] rd_data;
    logic [LEN_W-1:0]  cap_count;
    logic [ADDR_W:0]   end_addr;
    logic              range_bad;
    logic              wr_en;

    // Last beat address computed one bit wider so a crossing of DEPTH-1 cannot wrap.
    assign cap_count = op_type[1] ? len_in : '0;
    assign end_addr  = {1'b0, addr_in} + (ADDR_W+1)'(cap_count);
    assign range_bad = (end_addr >= (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
        end else if (scan_en) begin
            ctrl_q <= ctrl_t'({ctrl_q[CHAIN_L-2:0], scan_in});
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    always_comb begin
        ctrl_d             = ctrl_q;
        ctrl_d.done        = 1'b0;
        ctrl_d.err         = 1'b0;
        ctrl_d.rdata_valid = 1'b0;

        case (ctrl_q.state)
            ST_IDLE: begin
                if (start_op && !scan_en) begin
                    ctrl_d.op       = op_t'(op_type);
                    ctrl_d.cur_addr = addr_in;
                    ctrl_d.count    = cap_count;
                    if (range_bad) begin
                        ctrl_d.state = ST_ERR;
                        ctrl_d.done  = 1'b1;
                        ctrl_d.err   = 1'b1;
                    end else if (op_type[0]) begin
                        ctrl_d.state = ST_WR;
                    end else begin
                        ctrl_d.state = ST_RD;
                    end
                end
            end
            ST_RD, ST_WR: begin
                if (ctrl_q.state == ST_RD) begin
                    ctrl_d.data_out    = rd_data;
                    ctrl_d.rdata_valid = 1'b1;
                end
                if (ctrl_q.count == '0) begin
                    ctrl_d.state = ST_DONE;
                    ctrl_d.done  = 1'b1;
                end else begin
                    ctrl_d.cur_addr = ctrl_q.cur_addr + ADDR_W'(1);
                    ctrl_d.count    = ctrl_q.count - LEN_W'(1);
                end
            end
            ST_DONE, ST_ERR: begin
                ctrl_d.state = ST_IDLE;
            end
            default: begin
                ctrl_d.state = ST_IDLE;
            end
        endcase
    end

    assign wr_en = (ctrl_q.state == ST_WR) && !scan_en;

    // Read address is the next cur_addr so the registered array output lines up with the RD cycle.
    sram_array_p #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ctrl_q.cur_addr),
        .wr_data (data_in),
        .rd_addr (ctrl_d.cur_addr),
        .rd_data (rd_data)
    );

    assign scan_out    = ctrl_q.rdata_valid;
    assign data_out    = ctrl_q.data_out;
    assign rdata_valid = ctrl_q.rdata_valid;
    assign done        = ctrl_q.done;
    assign err         = ctrl_q.err;
    assign busy        = (ctrl_q.state != ST_IDLE);
    assign wdata_ready = wr_en;

endmodule
